// File: rtl/beta_lsu_if.sv
// Data-memory port: request channel (req/gnt) with address, store data and byte enables, plus read return (rvalid/rdata).
// Latency: none, this is wiring only.
// Backpressure: the master holds req and its payload stable until gnt; rvalid cannot be stalled.
interface beta_lsu_if;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/beta_lsu.sv
// Load/store unit: aligns store lanes, extracts and extends load data over a req/gnt/rvalid port.
// Latency: request 1 cycle after accept; st_done 1 cycle after gnt; writeback 1 cycle after rvalid.
// Backpressure: busy_o holds upstream from the cycle after accept until completion, fault or timeout.
module beta_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        mem_op_en_i,
    input  logic        mem_op_i,
    input  logic [1:0]  mem_op_size_i,
    input  logic        not_sign_ext_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    input  logic [4:0]  rd_i,
    output logic        busy_o,
    beta_lsu_if.master  dmem,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        st_done_o,
    output logic        misaligned_o,
    output logic        bus_err_o,
    output logic [31:0] exc_addr_o
);
    localparam logic       MEM_STORE_OP = 1'b1;
    localparam logic [1:0] SZ_BYTE      = 2'b00;
    localparam logic [1:0] SZ_HALF      = 2'b01;
    localparam logic [1:0] SZ_WORD      = 2'b10;
    localparam int         CW           = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW:0] TO_LIM      = TIMEOUT_CYCLES[CW:0];

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    state_t         state_q, state_d;
    logic           op_q, op_d;
    logic [1:0]     size_q, size_d;
    logic           zext_q, zext_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    data_q, data_d;
    logic [4:0]     rd_q, rd_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           wb_valid_q, wb_valid_d;
    logic [4:0]     wb_rd_q, wb_rd_d;
    logic [31:0]    wb_data_q, wb_data_d;
    logic           st_done_q, st_done_d;
    logic           misaligned_q, misaligned_d;
    logic           bus_err_q, bus_err_d;
    logic [31:0]    exc_addr_q, exc_addr_d;

    logic           fault;
    logic           timeout_hit;
    logic [CW:0]    cnt_nxt;
    logic [3:0]     be_lane;
    logic [31:0]    wdata_lane;
    logic [31:0]    rshift;
    logic [31:0]    load_ext;
    logic           in_req;

    always_comb begin
        fault = 1'b0;
        case (mem_op_size_i)
            SZ_BYTE: fault = 1'b0;
            SZ_HALF: fault = addr_i[0];
            SZ_WORD: fault = |addr_i[1:0];
            default: fault = 1'b1;
        endcase
    end

    // The extra top bit lets the compare reach TIMEOUT_CYCLES without the counter itself wrapping.
    assign cnt_nxt     = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_nxt == TO_LIM);

    always_comb begin
        be_lane    = 4'b1111;
        wdata_lane = data_q;
        case (size_q)
            SZ_BYTE: begin
                be_lane    = 4'b0001 << addr_q[1:0];
                wdata_lane = {4{data_q[7:0]}};
            end
            SZ_HALF: begin
                be_lane    = 4'b0011 << addr_q[1:0];
                wdata_lane = {2{data_q[15:0]}};
            end
            default: ;
        endcase
    end

    assign rshift = dmem.rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_ext = rshift;
        case (size_q)
            SZ_BYTE: load_ext = {{24{rshift[7] & ~zext_q}}, rshift[7:0]};
            SZ_HALF: load_ext = {{16{rshift[15] & ~zext_q}}, rshift[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        size_d       = size_q;
        zext_d       = zext_q;
        addr_d       = addr_q;
        data_d       = data_q;
        rd_d         = rd_q;
        cnt_d        = cnt_q;
        wb_valid_d   = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        st_done_d    = 1'b0;
        misaligned_d = 1'b0;
        bus_err_d    = 1'b0;
        exc_addr_d   = exc_addr_q;
        case (state_q)
            S_IDLE: begin
                if (mem_op_en_i) begin
                    if (fault) begin
                        misaligned_d = 1'b1;
                        exc_addr_d   = addr_i;
                    end else begin
                        op_d    = mem_op_i;
                        size_d  = mem_op_size_i;
                        zext_d  = not_sign_ext_i;
                        addr_d  = addr_i;
                        data_d  = store_data_i;
                        rd_d    = rd_i;
                        cnt_d   = '0;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (dmem.gnt) begin
                    cnt_d = '0;
                    if (op_q == MEM_STORE_OP) begin
                        st_done_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        state_d   = S_RESP;
                    end
                end else if (timeout_hit) begin
                    bus_err_d  = 1'b1;
                    exc_addr_d = addr_q;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_nxt[CW-1:0];
                end
            end
            S_RESP: begin
                // A response arriving on the final counted cycle still completes the load.
                if (dmem.rvalid) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = load_ext;
                    state_d    = S_IDLE;
                end else if (timeout_hit) begin
                    bus_err_d  = 1'b1;
                    exc_addr_d = addr_q;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_nxt[CW-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= S_IDLE;
            op_q         <= 1'b0;
            size_q       <= 2'b00;
            zext_q       <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            rd_q         <= '0;
            cnt_q        <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            st_done_q    <= 1'b0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
            exc_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            size_q       <= size_d;
            zext_q       <= zext_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            rd_q         <= rd_d;
            cnt_q        <= cnt_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            st_done_q    <= st_done_d;
            misaligned_q <= misaligned_d;
            bus_err_q    <= bus_err_d;
            exc_addr_q   <= exc_addr_d;
        end
    end

    // Bus payload is forced to zero outside REQ so reset and idle look identical on the port.
    assign in_req       = (state_q == S_REQ);
    assign busy_o       = (state_q != S_IDLE);
    assign dmem.req     = in_req;
    assign dmem.addr    = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign dmem.we      = in_req & (op_q == MEM_STORE_OP);
    assign dmem.be      = in_req ? be_lane : 4'b0000;
    assign dmem.wdata   = in_req ? wdata_lane : 32'h0;
    assign wb_valid_o   = wb_valid_q;
    assign wb_rd_o      = wb_rd_q;
    assign wb_data_o    = wb_data_q;
    assign st_done_o    = st_done_q;
    assign misaligned_o = misaligned_q;
    assign bus_err_o    = bus_err_q;
    assign exc_addr_o   = exc_addr_q;
endmodule

// File: tb/tb_beta_lsu.sv
// Bench for beta_lsu: literal checks of the documented cases plus a transaction-level reference model under random traffic.
module tb_beta_lsu;
    localparam int TO = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        m_en = 0, m_op = 0, m_zx = 0, t4_en = 0;
    logic [1:0]  m_size = 0;
    logic [31:0] m_addr = 0, m_data = 0, m_rdata = 0;
    logic [4:0]  m_rd = 0;
    logic        m_gnt = 0, m_rv = 0, t4_gnt = 0, t4_rv = 0;

    logic        busy, wbv, st, mis, berr;
    logic [4:0]  wbrd;
    logic [31:0] wbdata, exc;
    logic        t4_busy, t4_wbv, t4_st, t4_mis, t4_berr;
    logic [4:0]  t4_wbrd;
    logic [31:0] t4_wbdata, t4_exc;

    beta_lsu_if bus();
    beta_lsu_if bus4();
    assign bus.gnt     = m_gnt;
    assign bus.rvalid  = m_rv;
    assign bus.rdata   = m_rdata;
    assign bus4.gnt    = t4_gnt;
    assign bus4.rvalid = t4_rv;
    assign bus4.rdata  = 32'h0;

    beta_lsu #(.TIMEOUT_CYCLES(TO)) u_dut (
        .clk_i(clk), .rstn_i(rst_n), .mem_op_en_i(m_en), .mem_op_i(m_op),
        .mem_op_size_i(m_size), .not_sign_ext_i(m_zx), .addr_i(m_addr),
        .store_data_i(m_data), .rd_i(m_rd), .busy_o(busy), .dmem(bus),
        .wb_valid_o(wbv), .wb_rd_o(wbrd), .wb_data_o(wbdata), .st_done_o(st),
        .misaligned_o(mis), .bus_err_o(berr), .exc_addr_o(exc));

    beta_lsu #(.TIMEOUT_CYCLES(4)) u_to4 (
        .clk_i(clk), .rstn_i(rst_n), .mem_op_en_i(t4_en), .mem_op_i(m_op),
        .mem_op_size_i(m_size), .not_sign_ext_i(m_zx), .addr_i(m_addr),
        .store_data_i(m_data), .rd_i(m_rd), .busy_o(t4_busy), .dmem(bus4),
        .wb_valid_o(t4_wbv), .wb_rd_o(t4_wbrd), .wb_data_o(t4_wbdata), .st_done_o(t4_st),
        .misaligned_o(t4_mis), .bus_err_o(t4_berr), .exc_addr_o(t4_exc));

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_fault(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b11) return 1'b1;
        return (a % (32'd1 << sz)) != 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [1:0] off);
        int v;
        v = ((1 << (1 << sz)) - 1) << off;
        return v[3:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'b00) return {24'h0, d[7:0]} * 32'h01010101;
        if (sz == 2'b01) return {16'h0, d[15:0]} * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] ld_val(input logic [31:0] r, input logic [1:0] sz,
                                           input logic [1:0] off, input bit zx);
        int nb;
        logic [31:0] v, mask;
        nb = 1 << sz;
        if (nb == 4) return r;
        mask = (32'd1 << (8 * nb)) - 1;
        v = (r >> (8 * off)) & mask;
        if (!zx && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    // Reference model: one in-flight access, a granted flag and a waiting-cycle age.
    bit          pend = 0, granted = 0;
    int          age = 0;
    bit          q_st = 0, q_zx = 0;
    logic [1:0]  q_sz = 0;
    logic [31:0] q_addr = 0, q_data = 0;
    logic [4:0]  q_rd = 0;
    bit          e_st = 0, e_mis = 0, e_berr = 0, e_wb = 0;
    logic [31:0] e_exc = 0, e_data = 0;
    logic [4:0]  e_rd = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend = 0; granted = 0; age = 0;
            e_st = 0; e_mis = 0; e_berr = 0; e_wb = 0; e_exc = 0;
        end else begin
            e_st = 0; e_mis = 0; e_berr = 0; e_wb = 0;
            if (!pend) begin
                if (m_en) begin
                    if (is_fault(m_size, m_addr)) begin
                        e_mis = 1; e_exc = m_addr;
                    end else begin
                        pend = 1; granted = 0; age = 0;
                        q_st = m_op; q_sz = m_size; q_zx = m_zx;
                        q_addr = m_addr; q_data = m_data; q_rd = m_rd;
                    end
                end
            end else if (!granted && m_gnt) begin
                if (q_st) begin pend = 0; e_st = 1; end
                else begin granted = 1; age = 0; end
            end else if (granted && m_rv) begin
                pend = 0; e_wb = 1; e_rd = q_rd;
                e_data = ld_val(m_rdata, q_sz, q_addr[1:0], q_zx);
            end else begin
                age++;
                if (age >= TO) begin pend = 0; e_berr = 1; e_exc = q_addr; end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, pend);
            chk("dmem_req", bus.req, pend && !granted);
            chk("st_done", st, e_st);
            chk("misaligned", mis, e_mis);
            chk("bus_err", berr, e_berr);
            chk("wb_valid", wbv, e_wb);
            chk("exc_addr", exc, e_exc);
            if (pend && !granted) begin
                chk("dmem_addr", bus.addr, {q_addr[31:2], 2'b00});
                chk("dmem_we", bus.we, q_st);
                chk("dmem_be", bus.be, exp_be(q_sz, q_addr[1:0]));
                if (q_st) chk("dmem_wdata", bus.wdata, exp_wdata(q_sz, q_data));
            end
            if (e_wb) begin
                chk("wb_rd", wbrd, e_rd);
                chk("wb_data", wbdata, e_data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit s, input logic [1:0] sz, input bit zx, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] r, input bit to4);
        int n;
        n = 0;
        while ((to4 ? t4_busy : busy) && n < 50) begin step(); n++; end
        if (to4 ? t4_busy : busy) chk("issue_wait_idle", 1, 0);
        m_op = s; m_size = sz; m_zx = zx; m_addr = a; m_data = d; m_rd = r;
        if (to4) t4_en = 1; else m_en = 1;
        step();
        m_en = 0; t4_en = 0;
    endtask

    task automatic wait_sig(input int sel, input int budget, input string nm);
        logic v;
        v = 0;
        for (int i = 0; i < budget && !v; i++) begin
            @(negedge clk);
            v = (sel == 0) ? wbv : st;
        end
        chk(nm, v, 1);
    endtask

    task automatic rand_phase(input int n, input int pg, input int pr);
        for (int i = 0; i < n; i++) begin
            step();
            m_en   = ($urandom_range(0, 99) < 60);
            m_op   = 1'($urandom_range(0, 1));
            m_size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            m_addr = $urandom;
            if ($urandom_range(0, 1) == 1) m_addr[1:0] = 2'b00;
            m_zx    = 1'($urandom_range(0, 1));
            m_data  = $urandom;
            m_rd    = 5'($urandom_range(0, 31));
            m_gnt   = ($urandom_range(0, 99) < pg);
            m_rv    = ($urandom_range(0, 99) < pr);
            m_rdata = $urandom;
        end
        step();
        m_en = 0; m_gnt = 0; m_rv = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time %0t want finish before 400000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_req", bus.req, 0);
        chk("rst_exc", exc, 0);
        chk("rst_wbv", wbv, 0);
        chk_en = 1;
        step();

        // SB 0x1003, immediate grant
        m_gnt = 1;
        issue(1, 2'b00, 0, 32'h1003, 32'hAABBCCDD, 0, 0);
        @(negedge clk);
        chk("sb_req", bus.req, 1);
        chk("sb_addr", bus.addr, 32'h1000);
        chk("sb_be", bus.be, 4'b1000);
        chk("sb_wdata", bus.wdata, 32'hDDDDDDDD);
        chk("sb_we", bus.we, 1);
        @(negedge clk);
        chk("sb_done", st, 1);
        @(negedge clk);
        chk("sb_done_pulse", st, 0);
        step();

        // loads with rvalid also present (stray) during REQ
        m_rv = 1; m_rdata = 32'h00008000;
        issue(0, 2'b00, 0, 32'h2001, 0, 5, 0);
        wait_sig(0, 6, "lb_wb");
        chk("lb_data", wbdata, 32'hFFFFFF80);
        chk("lb_rd", wbrd, 5);
        step();
        issue(0, 2'b00, 1, 32'h2001, 0, 6, 0);
        wait_sig(0, 6, "lbu_wb");
        chk("lbu_data", wbdata, 32'h00000080);
        step();
        m_rdata = 32'h8001FFFF;
        issue(0, 2'b01, 1, 32'h2002, 0, 7, 0);
        wait_sig(0, 6, "lhu_wb");
        chk("lhu_data", wbdata, 32'h00008001);
        step();
        issue(0, 2'b01, 0, 32'h2002, 0, 0, 0);
        wait_sig(0, 6, "lh_wb");
        chk("lh_data", wbdata, 32'hFFFF8001);
        chk("lh_rd0", wbrd, 0);
        step();
        m_rv = 0;

        // faults
        issue(0, 2'b10, 0, 32'h3002, 0, 1, 0);
        @(negedge clk);
        chk("lw_mis", mis, 1);
        chk("lw_exc", exc, 32'h3002);
        chk("lw_noreq", bus.req, 0);
        step();
        issue(0, 2'b11, 0, 32'h3000, 0, 1, 0);
        @(negedge clk);
        chk("rsv_mis", mis, 1);
        chk("rsv_exc", exc, 32'h3000);
        chk("rsv_busy", busy, 0);
        step();

        // grant withheld 5 cycles, stray rvalid throughout
        m_gnt = 0; m_rv = 1;
        issue(1, 2'b01, 0, 32'h4002, 32'h12345678, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_req", bus.req, 1);
            chk("hold_addr", bus.addr, 32'h4000);
            chk("hold_be", bus.be, 4'b1100);
            chk("hold_wdata", bus.wdata, 32'h56785678);
            chk("hold_busy", busy, 1);
        end
        step();
        m_gnt = 1;
        wait_sig(1, 4, "hold_done");
        m_gnt = 0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_stray_rv", wbv, 0);
        end
        step();
        m_rv = 0;

        // timeout on the TIMEOUT_CYCLES=4 instance
        t4_gnt = 1; t4_rv = 0;
        issue(0, 2'b10, 0, 32'h5000, 0, 9, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("to4_busy", t4_busy, 1);
            chk("to4_noerr", t4_berr, 0);
        end
        @(negedge clk);
        chk("to4_berr", t4_berr, 1);
        chk("to4_idle", t4_busy, 0);
        chk("to4_exc", t4_exc, 32'h5000);
        step();
        t4_rv = 1;
        repeat (3) begin
            @(negedge clk);
            chk("to4_late_rv", t4_wbv, 0);
        end
        step();
        t4_rv = 0; t4_gnt = 0;

        // asynchronous reset while waiting in RESP
        m_gnt = 1; m_rv = 0;
        issue(0, 2'b10, 0, 32'h6000, 0, 3, 0);
        step();
        m_gnt = 0;
        #2 rst_n = 0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_req", bus.req, 0);
        chk("arst_exc", exc, 0);
        m_rv = 1;
        step();
        step();
        rst_n = 1;
        repeat (3) begin
            @(negedge clk);
            chk("arst_no_wb", wbv, 0);
        end
        step();
        m_rv = 0;

        rand_phase(1500, 55, 50);
        rand_phase(1500, 30, 30);
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
